// File: rtl/iic_req_arbiter.sv
// iic_req_arbiter: shares one iic_drive instance among N_REQ requesters.
// Winner selection is round-robin by default. Defining IIC_ARB_FIXED_PRIO_EN switches to
// fixed priority, where the lowest index wins and the pointer stays at 0.
// The driver's busy/err come from the slower clk_i domain and are double-flopped here.
module iic_req_arbiter #(
  parameter int unsigned N_REQ    = 3,
  parameter int unsigned START_TO = 255,
  parameter int unsigned BUSY_TO  = 65535
) (
  input  logic                  clk_8m,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      req_wr_rd,
  input  logic [8*N_REQ-1:0]    req_dev_addr,
  input  logic [16*N_REQ-1:0]   req_reg,
  input  logic [8*N_REQ-1:0]    req_wdata,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      done,
  output logic                  done_err,
  output logic [7:0]            rd_data_out,
  output logic                  arb_busy,
  output logic                  start_en,
  output logic                  wr_rd_flag,
  output logic [7:0]            i2c_device_addr,
  output logic [15:0]           register,
  output logic [7:0]            data_byte,
  input  logic                  busy,
  input  logic                  err,
  input  logic [7:0]            rd_data
);

  localparam int unsigned      PtrW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [15:0]      StartTo = 16'(START_TO);
  localparam logic [15:0]      BusyTo  = 16'(BUSY_TO);
  localparam logic [N_REQ-1:0] GntBase = N_REQ'(1);
  localparam logic [PtrW-1:0]  LastIdx = PtrW'(N_REQ - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

  state_e          state_q;
  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] gnt_idx_q;
  logic [15:0]     cnt_q;
  logic [15:0]     cnt_inc;
  logic            busy_meta_q, busy_s_q;
  logic            err_meta_q, err_s_q;
  logic            err_lat_q;
  logic            err_next;
  logic            win_found;
  logic [PtrW-1:0] win_idx;
  logic [PtrW-1:0] scan_idx;
  int unsigned     scan_pos;

  assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign err_next = err_lat_q | err_s_q;
  assign arb_busy = (state_q != StIdle);

  // Two-flop synchronisers for the driver's clk_i-domain status
  always_ff @(posedge clk_8m or negedge rst_n) begin
    if (!rst_n) begin
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
      err_meta_q  <= 1'b0;
      err_s_q     <= 1'b0;
    end else begin
      busy_meta_q <= busy;
      busy_s_q    <= busy_meta_q;
      err_meta_q  <= err;
      err_s_q     <= err_meta_q;
    end
  end

  // Winner search: first set request at or above ptr_q, wrapping around.
  // In fixed-priority builds ptr_q is held at 0, so the scan starts at index 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_pos  = 0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan_pos = 32'(ptr_q) + i;
      if (scan_pos >= N_REQ) begin
        scan_pos = scan_pos - N_REQ;
      end
      scan_idx = PtrW'(scan_pos);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Main FSM: grant, driver handshake with timeouts, completion and pointer update
  always_ff @(posedge clk_8m or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      ptr_q           <= '0;
      gnt_idx_q       <= '0;
      cnt_q           <= '0;
      err_lat_q       <= 1'b0;
      gnt             <= '0;
      done            <= '0;
      done_err        <= 1'b0;
      rd_data_out     <= '0;
      start_en        <= 1'b0;
      wr_rd_flag      <= 1'b0;
      i2c_device_addr <= '0;
      register        <= '0;
      data_byte       <= '0;
    end else begin
      done     <= '0;
      done_err <= 1'b0;
      cnt_q    <= cnt_inc;
      unique case (state_q)
        StIdle: begin
          cnt_q     <= '0;
          err_lat_q <= 1'b0;
          if (win_found) begin
            gnt             <= GntBase << win_idx;
            gnt_idx_q       <= win_idx;
            wr_rd_flag      <= req_wr_rd[win_idx];
            i2c_device_addr <= req_dev_addr[{win_idx, 3'b000} +: 8];
            register        <= req_reg[{win_idx, 4'b0000} +: 16];
            data_byte       <= req_wdata[{win_idx, 3'b000} +: 8];
            start_en        <= 1'b1;
            state_q         <= StStart;
          end
        end
        StStart: begin
          if (busy_s_q) begin
            start_en  <= 1'b0;
            err_lat_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= StWait;
          end else if (cnt_inc == StartTo) begin
            // Driver never acknowledged: report as an error
            start_en <= 1'b0;
            cnt_q    <= '0;
            done     <= gnt;
            done_err <= 1'b1;
            state_q  <= StDone;
          end
        end
        StWait: begin
          err_lat_q <= err_next;
          if (!busy_s_q) begin
            cnt_q    <= '0;
            done     <= gnt;
            done_err <= err_next;
            // Keep the previous read byte on errors or writes
            if (wr_rd_flag && !err_next) begin
              rd_data_out <= rd_data;
            end
            state_q <= StDone;
          end else if (cnt_inc == BusyTo) begin
            cnt_q    <= '0;
            done     <= gnt;
            done_err <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          gnt     <= '0;
          cnt_q   <= '0;
`ifdef IIC_ARB_FIXED_PRIO_EN
          ptr_q   <= '0;
`else
          ptr_q   <= (gnt_idx_q == LastIdx) ? '0 : gnt_idx_q + 1'b1;
`endif
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
